// File: rtl/button_repeat_debouncer.sv
// button_repeat_debouncer: N-channel button front end.
// Each channel synchronises its raw pin, debounces it, and emits press/release
// pulses plus typematic auto-repeat pulses while the button stays held.

// Single-channel datapath: two-flop synchroniser, debounce counter, repeat FSM.
module button_repeat_channel #(
    parameter int LOG_DEBOUNCE_COUNT = 20,
    parameter int LOG_WAIT_COUNT     = 25,
    parameter int LOG_REPEAT_COUNT   = 23,
    parameter int ACTIVE_LOW_IN      = 0
) (
    input  logic clk_in,
    input  logic rst_in_n,
    input  logic btn_in,
    input  logic repeat_en_in,
    output logic level_out,
    output logic press_out,
    output logic release_out,
    output logic repeat_out,
    output logic action_out
);
    localparam int DW = LOG_DEBOUNCE_COUNT + 1;
    localparam int HW = ((LOG_WAIT_COUNT > LOG_REPEAT_COUNT) ? LOG_WAIT_COUNT : LOG_REPEAT_COUNT) + 1;
    localparam logic [DW-1:0] DB_LAST   = DW'((64'd1 << LOG_DEBOUNCE_COUNT) - 64'd1);
    localparam logic [HW-1:0] WAIT_LAST = HW'((64'd1 << LOG_WAIT_COUNT) - 64'd1);
    localparam logic [HW-1:0] REP_LAST  = HW'((64'd1 << LOG_REPEAT_COUNT) - 64'd1);
    localparam logic          INV       = (ACTIVE_LOW_IN != 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REPEAT} state_t;

    logic          s1, s2, level;
    logic [DW-1:0] db_cnt;
    logic          db_flip, rise, fall;
    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;
    logic          rep_pulse;

    // The level flips on the DB-th consecutive cycle that s2 disagrees with it.
    assign db_flip = (s2 != level) && (db_cnt == DB_LAST);
    assign rise    = db_flip && s2;
    assign fall    = db_flip && !s2;

    // Synchroniser and debounce counter; any agreeing cycle restarts the count.
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1 <= btn_in ^ INV;
            s2 <= s1;
            if (s2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level  <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Repeat FSM state and hold counter register.
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Next state: release wins over everything; WAIT saturates until enabled.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        if (fall) begin
            state_nxt    = ST_IDLE;
            hold_cnt_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state_nxt    = ST_WAIT;
                        hold_cnt_nxt = '0;
                    end
                end
                ST_WAIT: begin
                    if (hold_cnt == WAIT_LAST) begin
                        if (repeat_en_in) begin
                            state_nxt    = ST_REPEAT;
                            hold_cnt_nxt = '0;
                        end
                    end else begin
                        hold_cnt_nxt = hold_cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (hold_cnt == REP_LAST) hold_cnt_nxt = '0;
                    else                      hold_cnt_nxt = hold_cnt + 1'b1;
                end
                default: begin
                    state_nxt    = ST_IDLE;
                    hold_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Repeat pulse decode; suppressed on the release edge.
    always_comb begin
        rep_pulse = 1'b0;
        if (!fall && repeat_en_in) begin
            if (state == ST_WAIT && hold_cnt == WAIT_LAST)  rep_pulse = 1'b1;
            if (state == ST_REPEAT && hold_cnt == REP_LAST) rep_pulse = 1'b1;
        end
    end

    // Registered pulse outputs, aligned with the level change.
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            press_out   <= 1'b0;
            release_out <= 1'b0;
            repeat_out  <= 1'b0;
            action_out  <= 1'b0;
        end else begin
            press_out   <= rise;
            release_out <= fall;
            repeat_out  <= rep_pulse;
            action_out  <= rise | rep_pulse;
        end
    end

    assign level_out = level;
endmodule

// Top: one independent channel per button.
module button_repeat_debouncer #(
    parameter int NUM_CH             = 5,
    parameter int LOG_DEBOUNCE_COUNT = 20,
    parameter int LOG_WAIT_COUNT     = 25,
    parameter int LOG_REPEAT_COUNT   = 23,
    parameter int ACTIVE_LOW_IN      = 0
) (
    input  logic              clk_in,
    input  logic              rst_in_n,
    input  logic [NUM_CH-1:0] btn_in,
    input  logic [NUM_CH-1:0] repeat_en_in,
    output logic [NUM_CH-1:0] level_out,
    output logic [NUM_CH-1:0] press_out,
    output logic [NUM_CH-1:0] release_out,
    output logic [NUM_CH-1:0] repeat_out,
    output logic [NUM_CH-1:0] action_out
);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        button_repeat_channel #(
            .LOG_DEBOUNCE_COUNT(LOG_DEBOUNCE_COUNT),
            .LOG_WAIT_COUNT    (LOG_WAIT_COUNT),
            .LOG_REPEAT_COUNT  (LOG_REPEAT_COUNT),
            .ACTIVE_LOW_IN     (ACTIVE_LOW_IN)
        ) u_ch (
            .clk_in      (clk_in),
            .rst_in_n    (rst_in_n),
            .btn_in      (btn_in[c]),
            .repeat_en_in(repeat_en_in[c]),
            .level_out   (level_out[c]),
            .press_out   (press_out[c]),
            .release_out (release_out[c]),
            .repeat_out  (repeat_out[c]),
            .action_out  (action_out[c])
        );
    end
endmodule

// File: doc/button_repeat_debouncer.md
Name: button_repeat_debouncer

Overview:
- Parametrised N-channel successor to the single-button debounce/wait logic in the game-of-life top level.
- Synchronises raw button inputs (btnl/btnu/btnr/btnd/btnc and any future inputs), then debounces each one.
- Per channel it produces a debounced level, press and release pulses, and typematic auto-repeat pulses.
- Sits between the board pins and the cursor/edit/step control logic, so that held direction buttons move the cursor continuously.

Parameters:
- NUM_CH, 5, number of independent button channels (1..32).
- LOG_DEBOUNCE_COUNT, 20, DB = 2^LOG_DEBOUNCE_COUNT consecutive stable cycles required to accept a level change.
- LOG_WAIT_COUNT, 25, WAIT = 2^LOG_WAIT_COUNT cycles from press to the first repeat pulse.
- LOG_REPEAT_COUNT, 23, REP = 2^LOG_REPEAT_COUNT cycles between subsequent repeat pulses.
- ACTIVE_LOW_IN, 0, 1 = raw inputs are inverted before synchronisation (pressed = 0 on pin).

Ports:
- clk_in  in  1  system clock (100 MHz domain)
- rst_in_n  in  1  reset, synchronous, active-low
- btn_in  in  NUM_CH  raw asynchronous button levels
- repeat_en_in  in  NUM_CH  per-channel auto-repeat enable; sampled every cycle
- level_out  out  NUM_CH  debounced level, 1 = pressed
- press_out  out  NUM_CH  1-cycle pulse on debounced 0->1
- release_out  out  NUM_CH  1-cycle pulse on debounced 1->0
- repeat_out  out  NUM_CH  1-cycle auto-repeat pulse while held
- action_out  out  NUM_CH  press_out | repeat_out (registered, same cycle)

Behaviour:
Clock and reset
- One clock, clk_in.
- Reset is synchronous and active-low (rst_in_n = 0 sampled at the posedge clk_in).

Reset values (every channel)
- Synchroniser flops 0, debounce counters 0, hold counters 0, repeat phase = IDLE.
- level_out, press_out, release_out, repeat_out, action_out all 0.
- A button held through reset is treated as released. It produces press_out after normal latency once rst_in_n = 1.
- Reset asserted mid-debounce or mid-hold aborts the operation immediately. Outputs are 0 on the edge following reset sampling.

Synchroniser
- Two flops per channel: s1 <= btn_in ^ ACTIVE_LOW_IN; s2 <= s1.

Debounce (per channel)
- Counter width LOG_DEBOUNCE_COUNT+1.
- If s2 == level: counter <= 0.
- Else, if counter == DB-1: level <= s2 and counter <= 0.
- Else: counter <= counter + 1.
- Any glitch shorter than DB cycles (as seen at s2) resets the counter; no output change.
- Latency: raw edge sampled into s1 at edge E0 -> level_out changes at edge E0+DB+1 (DB+2 cycles inclusive of E0).

Pulses (registered, asserted on the same edge level_out changes)
- press_out on 0->1; release_out on 1->0. Never both in the same cycle.

Repeat FSM (per channel), states IDLE, WAIT, REPEAT
- IDLE: on press, hold counter <= 0, go to WAIT.
- WAIT: counter increments each cycle.
  - When counter reaches WAIT-1: if repeat_en_in = 1, pulse repeat_out, counter <= 0, go to REPEAT.
  - If repeat_en_in = 0, stay in WAIT saturated at WAIT-1, with no pulse.
- REPEAT: when counter reaches REP-1, pulse repeat_out if repeat_en_in = 1, then counter <= 0.
- Any state: release (level 1->0) -> IDLE, counter 0, no repeat_out that cycle. Release has priority over a coincident repeat.
- Result: first repeat pulse is WAIT cycles after the press pulse; subsequent pulses every REP cycles.
- Counter width max(LOG_WAIT_COUNT, LOG_REPEAT_COUNT)+1; no wrap can occur because the counter is cleared at the terminal value.

Channels and output ordering
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- action_out = press_out | repeat_out. press_out and repeat_out are never coincident because the first repeat comes ≥ WAIT ≥ 1 cycle after press.

Test Plan:
Bench parameters: NUM_CH=5, LOG_DEBOUNCE_COUNT=1 (DB=2), LOG_WAIT_COUNT=2 (WAIT=4), LOG_REPEAT_COUNT=1 (REP=2), ACTIVE_LOW_IN=0, 10 ns clock.

1. Reset: rst_in_n=0 for 2 cycles with btn_in=5'b11111 -> all outputs 0. After release, level_out=5'b11111 with press_out=5'b11111 exactly DB+2=4 cycles after the first clean sampling edge.
2. Glitch reject: btn_in[0] high for 1 cycle, then low -> level_out[0], press_out[0] stay 0. Hold 2 cycles -> press_out[0] single pulse at E0+3.
3. Auto-repeat: repeat_en_in=all 1, hold btn_in[4] (btnc) 20 cycles -> press at t, repeat_out[4] at t+4, t+6, t+8, ... After release, release_out[4] once and no further repeats.
4. Repeat disabled: repeat_en_in[2]=0, hold btn_in[2] 20 cycles -> press only, zero repeat_out[2]. Set repeat_en_in[2]=1 mid-hold -> repeat_out[2] on the next edge (saturated WAIT), then every 2 cycles.
5. Release/repeat collision: release timed so level falls on the same edge the repeat counter hits REP-1 -> release_out=1, repeat_out=0, FSM returns to IDLE.
6. Reset mid-hold: assert rst_in_n=0 during REPEAT with the button still held -> outputs 0 next edge. After deassert, a fresh press pulse comes after 4 cycles and the first repeat 4 cycles later.
